data_mem_responder: RTL and testbench



---
 rtl/data_mem_if.sv | 27 ++
 rtl/data_mem_responder.sv | 137 +++++++++++++
 tb/tb_data_mem_responder.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_if.sv
// CPU data-memory port bundle: request signals from the CPU, read data and ready from the memory.
interface data_mem_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 5
);
    logic              r_w;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data_mem_in;
    logic [DATA_W-1:0] data_mem_out;
    logic              ready;

    modport master (
        output r_w,
        output addr,
        output data_mem_in,
        input  data_mem_out,
        input  ready
    );

    modport slave (
        input  r_w,
        input  addr,
        input  data_mem_in,
        output data_mem_out,
        output ready
    );
endinterface

// File: rtl/data_mem_responder.sv
// data_mem_responder: word-addressed data RAM for a single-cycle CPU.
// Reads are combinational, writes commit on the rising edge. After every reset a
// clear sequencer writes CLEAR_VAL to every word before ready rises.
// Optional macro DMEM_MMIO_TIMER_EN: the top word becomes a loadable free-running
// cycle counter instead of RAM.
module data_mem_responder #(
    parameter int unsigned       DATA_W    = 16,
    parameter int unsigned       ADDR_W    = 5,
    parameter int unsigned       DEPTH     = 32,
    parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
    input  logic      clk,
    input  logic      rst_n,
    data_mem_if.slave bus
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
`ifdef DMEM_MMIO_TIMER_EN
    localparam int unsigned RAM_WORDS = DEPTH - 1;
`else
    localparam int unsigned RAM_WORDS = DEPTH;
`endif

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
    logic              ready_q;

    logic              mem_we_c;
    logic [ADDR_W-1:0] mem_waddr_c;
    logic [DATA_W-1:0] mem_wdata_c;
    logic [DATA_W-1:0] rd_data_c;

    logic [DATA_W-1:0] mem [RAM_WORDS];

    // State, clear pointer and ready registers; reset restarts the clear sequence.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= CLEAR;
            clr_ptr_q <= '0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
            ready_q   <= (state_d == RUN);
        end
    end

    // Next state: walk the clear pointer over every word, then settle in RUN.
    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        case (state_q)
            CLEAR: begin
                clr_ptr_d = clr_ptr_q + ADDR_W'(1);
                if (clr_ptr_q == LAST_ADDR) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                state_d = RUN;
            end
            default: begin
                state_d   = CLEAR;
                clr_ptr_d = '0;
            end
        endcase
    end

    // Write-port select: clear sequencer owns the port in CLEAR, the CPU in RUN.
    // An X on r_w fails the if-test, so it behaves as a read.
    always_comb begin
        mem_we_c    = 1'b0;
        mem_waddr_c = bus.addr;
        mem_wdata_c = bus.data_mem_in;
        if (state_q == CLEAR) begin
            mem_we_c    = rst_n;
            mem_waddr_c = clr_ptr_q;
            mem_wdata_c = CLEAR_VAL;
        end else if (bus.r_w == 1'b1) begin
            mem_we_c = 1'b1;
        end
`ifdef DMEM_MMIO_TIMER_EN
        if (mem_waddr_c == LAST_ADDR) begin
            mem_we_c = 1'b0;
        end
`endif
    end

    // RAM array write; no reset, contents are rebuilt by the clear sequence.
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            mem[mem_waddr_c] <= mem_wdata_c;
        end
    end

`ifdef DMEM_MMIO_TIMER_EN
    logic [DATA_W-1:0] tmr_q;

    // Cycle counter at the top address: held at zero while clearing, loadable by CPU writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmr_q <= '0;
        end else if (state_q == CLEAR) begin
            tmr_q <= '0;
        end else if (bus.r_w == 1'b1 && bus.addr == LAST_ADDR) begin
            tmr_q <= bus.data_mem_in;
        end else begin
            tmr_q <= tmr_q + DATA_W'(1);
        end
    end
`endif

    // Combinational read path; forced to zero until the clear sequence finishes.
    always_comb begin
        rd_data_c = '0;
        if (state_q == RUN) begin
`ifdef DMEM_MMIO_TIMER_EN
            if (bus.addr == LAST_ADDR) begin
                rd_data_c = tmr_q;
            end else begin
                rd_data_c = mem[bus.addr];
            end
`else
            rd_data_c = mem[bus.addr];
`endif
        end
    end

    assign bus.data_mem_out = rd_data_c;
    assign bus.ready        = ready_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: reference word model plus a queue of
// pending read expectations drained against the DUT read port.
module tb_data_mem_responder;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DEPTH  = 32;

    typedef struct {
        string             tag;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] exp;
    } rd_exp_t;

    logic clk;
    logic rst_n;

    data_mem_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    data_mem_responder #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .DEPTH    (DEPTH),
        .CLEAR_VAL(16'h0000)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    logic [DATA_W-1:0] model [DEPTH];
    rd_exp_t           sb [$];
    int                n_checks = 0;
    int                n_errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < int'(DEPTH); i++) model[i] = 16'h0000;
    endtask

    task automatic push_read(input string tag, input logic [ADDR_W-1:0] a);
        rd_exp_t e;
        e.tag  = tag;
        e.addr = a;
        e.exp  = model[a];
        sb.push_back(e);
    endtask

    task automatic drain();
        rd_exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(negedge clk);
            bus.r_w  = 1'b0;
            bus.addr = e.addr;
            #2;
            chk(e.tag, bus.data_mem_out, e.exp);
        end
    endtask

    task automatic write_word(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        @(negedge clk);
        bus.r_w         = 1'b1;
        bus.addr        = a;
        bus.data_mem_in = d;
        @(posedge clk);
        #1;
        bus.r_w  = 1'b0;
        model[a] = d;
    endtask

    // Count exactly DEPTH edges from release; ready must rise only after the last one.
    task automatic wait_clear(input string tag);
        for (int i = 1; i <= int'(DEPTH); i++) begin
            @(posedge clk);
            #1;
            if (i == int'(DEPTH) - 1) chk({tag, "_ready_low"}, 16'(bus.ready), 16'h0000);
        end
        chk({tag, "_ready_high"}, 16'(bus.ready), 16'h0001);
    endtask

    initial begin
        rst_n           = 1'b0;
        bus.r_w         = 1'b0;
        bus.addr        = '0;
        bus.data_mem_in = '0;
        model_clear();

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ready", 16'(bus.ready), 16'h0000);
        chk("reset_out", bus.data_mem_out, 16'h0000);

        // Release; inject a CPU write at clear edge 10 that must be lost
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 1; i <= int'(DEPTH); i++) begin
            if (i == 10) begin
                bus.r_w         = 1'b1;
                bus.addr        = 5'd3;
                bus.data_mem_in = 16'h1234;
                #1;
                chk("clear_out_forced_zero", bus.data_mem_out, 16'h0000);
            end
            @(posedge clk);
            #1;
            bus.r_w = 1'b0;
            if (i == int'(DEPTH) - 1) chk("init_ready_low", 16'(bus.ready), 16'h0000);
        end
        chk("init_ready_high", 16'(bus.ready), 16'h0001);
        push_read("init_rd0", 5'd0);
        push_read("init_rd7", 5'd7);
        push_read("init_rd30", 5'd30);
        push_read("clear_write_lost", 5'd3);
        drain();

        // Basic write/read
        write_word(5'd5, 16'hBEEF);
        push_read("wr_rd5", 5'd5);
        push_read("wr_rd6_untouched", 5'd6);
        drain();

        // Same-address read and write in one cycle: old value before, new after
        write_word(5'd9, 16'h0001);
        @(negedge clk);
        bus.r_w         = 1'b1;
        bus.addr        = 5'd9;
        bus.data_mem_in = 16'h00FF;
        #2;
        chk("rw_same_pre", bus.data_mem_out, model[9]);
        @(posedge clk);
        #1;
        bus.r_w  = 1'b0;
        model[9] = 16'h00FF;
        chk("rw_same_post", bus.data_mem_out, model[9]);

        // Back-to-back writes to one address
        @(negedge clk);
        bus.r_w         = 1'b1;
        bus.addr        = 5'd12;
        bus.data_mem_in = 16'h1111;
        @(posedge clk);
        #1;
        model[12]       = 16'h1111;
        bus.data_mem_in = 16'h2222;
        #1;
        chk("b2b_first", bus.data_mem_out, model[12]);
        @(posedge clk);
        #1;
        bus.r_w   = 1'b0;
        model[12] = 16'h2222;
        chk("b2b_second", bus.data_mem_out, model[12]);
        push_read("b2b_persist", 5'd12);
        drain();

        // Top address: counter when compiled in, plain RAM otherwise
`ifdef DMEM_MMIO_TIMER_EN
        write_word(5'd31, 16'hFFFE);
        chk("tmr_load", bus.data_mem_out, 16'hFFFE);
        @(posedge clk);
        #1;
        chk("tmr_inc", bus.data_mem_out, 16'hFFFF);
        @(posedge clk);
        #1;
        chk("tmr_wrap", bus.data_mem_out, 16'h0000);
`else
        write_word(5'd31, 16'hDEAD);
        chk("top_ram_wr", bus.data_mem_out, 16'hDEAD);
        repeat (2) @(posedge clk);
        #1;
        chk("top_ram_hold", bus.data_mem_out, 16'hDEAD);
`endif

        // Reset mid-RUN: fill 0..4, pulse reset, everything re-cleared
        for (int i = 0; i < 5; i++) write_word(ADDR_W'(i), 16'hA5A5);
        push_read("fill_rd0", 5'd0);
        push_read("fill_rd4", 5'd4);
        drain();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrun_ready_async", 16'(bus.ready), 16'h0000);
        chk("midrun_out_zero", bus.data_mem_out, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        wait_clear("midrun");
        for (int i = 0; i < 5; i++) push_read($sformatf("midrun_rd%0d", i), ADDR_W'(i));
        push_read("midrun_rd5", 5'd5);
        drain();

        // Reset mid-CLEAR: a full-length clear must follow
        write_word(5'd20, 16'h5A5A);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        wait_clear("midclear");
        push_read("midclear_rd20", 5'd20);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
